// File: rtl/wvb_event_reader.sv
// ============================================================================
//  Module   : wvb_event_reader
//  Purpose  : Pops one event header, streams the event's samples out of the
//             circular waveform RAM on valid/ready, then pulses wvb_rddone.
//  Option   : WVB_EVENT_READER_EVT_CNT_EN enables the completed-event counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wvb_event_reader #(
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_DATA_WIDTH = 22,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_START_LSB  = 48,
  parameter int P_STOP_LSB   = 36
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  input  logic                    hdr_empty,
  output logic                    hdr_rdreq,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] wvb_rd_data,
  output logic                    wvb_rddone,
  output logic [P_HDR_WIDTH-1:0]  evt_hdr,
  output logic [P_DATA_WIDTH-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_sop,
  output logic                    dout_eop,
  output logic [31:0]             evt_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RD    = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]              r_state;
  logic [P_HDR_WIDTH-1:0]  r_evt_hdr;
  logic [P_ADR_WIDTH-1:0]  r_rd_addr;
  logic [P_ADR_WIDTH:0]    r_remain;
  logic                    r_first;
  logic                    r_inflight;
  logic                    r_inflight_sop;
  logic                    r_inflight_eop;
  logic [1:0]              r_occ;
  logic [P_DATA_WIDTH-1:0] r_data0;
  logic [P_DATA_WIDTH-1:0] r_data1;
  logic                    r_sop0;
  logic                    r_sop1;
  logic                    r_eop0;
  logic                    r_eop1;

  logic [P_ADR_WIDTH-1:0]  w_start;
  logic [P_ADR_WIDTH-1:0]  w_stop;
  logic [P_ADR_WIDTH:0]    w_len;
  logic                    w_pop_hdr;
  logic                    w_accept;
  logic                    w_credit;
  logic                    w_issue;

  assign w_start   = hdr_data[P_START_LSB +: P_ADR_WIDTH];
  assign w_stop    = hdr_data[P_STOP_LSB +: P_ADR_WIDTH];
  // start == stop+1 yields the full-buffer length 2**P_ADR_WIDTH
  assign w_len     = {1'b0, w_stop - w_start} + (P_ADR_WIDTH+1)'(1);
  assign w_pop_hdr = rst_n && (r_state == ST_IDLE) && !hdr_empty;
  assign w_accept  = (r_occ != 2'd0) && dout_ready;
  assign w_credit  = (({1'b0, r_occ} + {2'b00, r_inflight}) - {2'b00, w_accept}) < 3'd2;
  assign w_issue   = (r_state == ST_RD) && w_credit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_evt_hdr <= '0;
      r_rd_addr <= '0;
      r_remain  <= '0;
      r_first   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop_hdr) begin
            r_evt_hdr <= hdr_data;
            r_rd_addr <= w_start;
            r_remain  <= w_len;
            r_first   <= 1'b1;
            r_state   <= ST_RD;
          end
        end
        ST_RD: begin
          if (w_issue) begin
            r_rd_addr <= r_rd_addr + 1'b1;
            r_remain  <= r_remain - 1'b1;
            r_first   <= 1'b0;
            if (r_remain == (P_ADR_WIDTH+1)'(1)) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_accept && r_eop0) r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Tags travel with each read so the returning word knows its position
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight     <= 1'b0;
      r_inflight_sop <= 1'b0;
      r_inflight_eop <= 1'b0;
    end else begin
      r_inflight     <= w_issue;
      r_inflight_sop <= w_issue && r_first;
      r_inflight_eop <= w_issue && (r_remain == (P_ADR_WIDTH+1)'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ   <= 2'd0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_sop0  <= 1'b0;
      r_sop1  <= 1'b0;
      r_eop0  <= 1'b0;
      r_eop1  <= 1'b0;
    end else begin
      case ({r_inflight, w_accept})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_data0 <= wvb_rd_data;
            r_sop0  <= r_inflight_sop;
            r_eop0  <= r_inflight_eop;
          end else begin
            r_data1 <= wvb_rd_data;
            r_sop1  <= r_inflight_sop;
            r_eop1  <= r_inflight_eop;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_data0 <= r_data1;
          r_sop0  <= r_sop1;
          r_eop0  <= r_eop1;
          r_occ   <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_data0 <= wvb_rd_data;
            r_sop0  <= r_inflight_sop;
            r_eop0  <= r_inflight_eop;
          end else begin
            r_data0 <= r_data1;
            r_sop0  <= r_sop1;
            r_eop0  <= r_eop1;
            r_data1 <= wvb_rd_data;
            r_sop1  <= r_inflight_sop;
            r_eop1  <= r_inflight_eop;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WVB_EVENT_READER_EVT_CNT_EN
  logic [31:0] r_evt_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                  r_evt_cnt <= '0;
    else if (r_state == ST_DONE) r_evt_cnt <= r_evt_cnt + 32'd1;
  end

  assign evt_cnt = r_evt_cnt;
`else
  assign evt_cnt = '0;
`endif

  assign hdr_rdreq   = w_pop_hdr;
  assign wvb_rd_addr = r_rd_addr;
  assign wvb_rddone  = rst_n && (r_state == ST_DONE);
  assign evt_hdr     = r_evt_hdr;
  assign dout        = r_data0;
  assign dout_valid  = (r_occ != 2'd0);
  assign dout_sop    = r_sop0;
  assign dout_eop    = r_eop0;

endmodule

`default_nettype wire

// File: tb/tb_wvb_event_reader.sv
// ============================================================================
//  Module   : tb_wvb_event_reader
//  Purpose  : Randomised stream bench for wvb_event_reader against a
//             queue-based event/word reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wvb_event_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [79:0] hdr_data;
  logic        hdr_empty;
  logic        hdr_rdreq;
  logic [11:0] wvb_rd_addr;
  logic [21:0] wvb_rd_data;
  logic        wvb_rddone;
  logic [79:0] evt_hdr;
  logic [21:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_sop;
  logic        dout_eop;
  logic [31:0] evt_cnt;

  wvb_event_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hdr_data    (hdr_data),
    .hdr_empty   (hdr_empty),
    .hdr_rdreq   (hdr_rdreq),
    .wvb_rd_addr (wvb_rd_addr),
    .wvb_rd_data (wvb_rd_data),
    .wvb_rddone  (wvb_rddone),
    .evt_hdr     (evt_hdr),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_sop    (dout_sop),
    .dout_eop    (dout_eop),
    .evt_cnt     (evt_cnt)
  );

  always #5 clk = ~clk;

  logic [21:0] ram [0:4095];
  always @(posedge clk) wvb_rd_data <= ram[wvb_rd_addr];

  typedef struct {
    logic [21:0] d;
    logic        sop;
    logic        eop;
    logic [79:0] hdr;
  } exp_t;

  logic [79:0] hdr_q[$];
  exp_t        exp_q[$];

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  cnt_model = 0;
  int  lat_target = -1;
  int  acc_total = 0;
  int  mode = 0;
  int  pat_idx = 0;
  bit  pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  bit  pop_seen = 1'b0;
  bit  pop_prev = 1'b0;
  bit  eop_acc_prev = 1'b0;
  bit  stall_prev = 1'b0;
  bit  rst_req = 1'b0;
  logic [21:0] prev_d;
  logic        prev_sop;
  logic        prev_eop;

  task automatic check(input string tag, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [79:0] mk_hdr(input int s, input int e);
    logic [79:0] h;
    h = {$urandom, $urandom, $urandom};
    h[59:48] = 12'(s);
    h[47:36] = 12'(e);
    return h;
  endfunction

  task automatic sample();
    exp_t e;
    int   s, len;
    if (pop_prev) check("rdreq_pulse", hdr_rdreq, 0);
    pop_prev = hdr_rdreq;
    check("rddone", wvb_rddone, eop_acc_prev && rst_n);
    check("evt_cnt", evt_cnt, cnt_model);
`ifdef WVB_EVENT_READER_EVT_CNT_EN
    if (eop_acc_prev && rst_n) cnt_model++;
`endif
    if (hdr_rdreq) begin
      check("pop_nonempty", hdr_empty, 0);
      pop_seen = 1'b1;
      s   = int'(hdr_data[59:48]);
      len = ((int'(hdr_data[47:36]) - s) & 4095) + 1;
      for (int i = 0; i < len; i++) begin
        e.d   = ram[(s + i) & 4095];
        e.sop = (i == 0);
        e.eop = (i == len - 1);
        e.hdr = hdr_data;
        exp_q.push_back(e);
      end
      lat_target = cyc + 3;
    end
    if (cyc == lat_target - 1) check("lat_early", dout_valid, 0);
    if (cyc == lat_target) begin
      check("lat_valid", dout_valid, 1);
      check("lat_sop", dout_sop, 1);
    end
    if (stall_prev) begin
      check("stall_valid", dout_valid, 1);
      check("stall_data", dout, prev_d);
      check("stall_sop", dout_sop, prev_sop);
      check("stall_eop", dout_eop, prev_eop);
    end
    eop_acc_prev = 1'b0;
    if (dout_valid && dout_ready) begin
      acc_total++;
      if (exp_q.size() == 0) begin
        check("extra_word", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("data", dout, e.d);
        check("sop", dout_sop, e.sop);
        check("eop", dout_eop, e.eop);
        if (e.sop) check("evt_hdr", evt_hdr, e.hdr);
        eop_acc_prev = e.eop;
      end
    end
    stall_prev = dout_valid && !dout_ready;
    prev_d     = dout;
    prev_sop   = dout_sop;
    prev_eop   = dout_eop;
    if (!rst_n) begin
      exp_q.delete();
      stall_prev   = 1'b0;
      eop_acc_prev = 1'b0;
      pop_prev     = 1'b0;
      cnt_model    = 0;
      lat_target   = -1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (pop_seen) begin
      if (hdr_q.size() != 0) void'(hdr_q.pop_front());
      pop_seen = 1'b0;
    end
    hdr_empty = (hdr_q.size() == 0);
    hdr_data  = hdr_empty ? 80'h0 : hdr_q[0];
    rst_n     = !rst_req;
    if (rst_req)        dout_ready = 1'b0;
    else if (mode == 0) dout_ready = 1'b1;
    else if (mode == 1) dout_ready = ($urandom_range(0, 9) < 7);
    else begin
      dout_ready = pat[pat_idx % 6];
      pat_idx++;
    end
    @(negedge clk);
    sample();
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((hdr_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    repeat (4) step();
    check("drain_left", hdr_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    int s, len;
    for (int i = 0; i < 4096; i++) ram[i] = 22'($urandom);
    rst_n      = 1'b0;
    hdr_empty  = 1'b1;
    hdr_data   = '0;
    dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", dout_valid, 0);
    check("rst_rdreq", hdr_rdreq, 0);
    check("rst_rddone", wvb_rddone, 0);
    check("rst_addr", wvb_rd_addr, 0);
    check("rst_hdr", evt_hdr, 0);
    check("rst_dout", dout, 0);
    check("rst_cnt", evt_cnt, 0);

    // back-to-back events incl. wrap and single word
    mode = 0;
    hdr_q.push_back(mk_hdr('h010, 'h013));
    hdr_q.push_back(mk_hdr('hFFE, 'h001));
    hdr_q.push_back(mk_hdr('h055, 'h055));
    run_idle(200);
`ifdef WVB_EVENT_READER_EVT_CNT_EN
    check("evt_cnt_three", evt_cnt, 3);
`else
    check("evt_cnt_three", evt_cnt, 0);
`endif

    mode = 2;
    hdr_q.push_back(mk_hdr('h020, 'h027));
    run_idle(200);

    mode = 1;
    hdr_q.push_back(mk_hdr('h100, 'h0FF));
    run_idle(20000);

    for (int k = 0; k < 8; k++) begin
      s   = $urandom_range(0, 4095);
      len = $urandom_range(1, 40);
      hdr_q.push_back(mk_hdr(s, (s + len - 1) & 4095));
    end
    run_idle(2000);

    // reset in the middle of an event
    mode = 0;
    hdr_q.push_back(mk_hdr('h200, 'h207));
    hdr_q.push_back(mk_hdr('h300, 'h303));
    acc_total = 0;
    for (int n = 0; n < 100 && acc_total < 2; n++) step();
    check("pre_rst_acc", acc_total, 2);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    check("midrst_valid", dout_valid, 0);
    check("midrst_rddone", wvb_rddone, 0);
    check("midrst_hdrq", hdr_q.size(), 1);
    run_idle(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
